// File: rtl/alu_pkg.sv
// Shared constants and types for the shared ALU resources.
// The clz arbiter takes its default sizes from here.
package alu_pkg;

  localparam int CLZ_DATAWIDTH = 32;
  localparam int CLZ_NREQ      = 4;
  localparam int CLZ_IDW       = $clog2(CLZ_NREQ);

  typedef logic [CLZ_IDW-1:0] clz_id_t;

endpackage

// File: rtl/clz.sv
// Combinational count-leading-zeros unit.
// A zero operand yields W.
module clz #(
  parameter int DATAWIDTH = 32,
  parameter int CW        = $clog2(DATAWIDTH) + 1
) (
  input  logic [DATAWIDTH-1:0] data,
  output logic [CW-1:0]        count
);

  logic found;

  always_comb begin
    found = 1'b0;
    count = CW'(DATAWIDTH);
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        found = 1'b1;
        count = CW'(DATAWIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps, so ptr is the highest-priority requester.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  // ptr is always below N, so one conditional subtract is enough to wrap
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/clz_arbiter.sv
// Shares one clz unit between NREQ requesters. Requesters are picked round-robin
// and results come back through a single registered valid/ready output stage.
module clz_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ      = CLZ_NREQ,
  parameter int DATAWIDTH = CLZ_DATAWIDTH,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATAWIDTH-1:0]      resp_cnt,
  output logic [IDW-1:0]            resp_id
);

  localparam int CW = $clog2(DATAWIDTH) + 1;

  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_next;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_idx;
  logic                 accept;
  logic                 handshake;
  logic [DATAWIDTH-1:0] operand;
  logic [CW-1:0]        clz_count;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Gating with rst_n keeps req_ready low during reset, when resp_valid alone would accept
  assign accept    = !resp_valid || resp_ready;
  assign req_ready = (accept && rst_n) ? grant : '0;
  assign handshake = |req_ready;
  assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot AND-OR mux keeps the grant-to-clz path shallow
  always_comb begin
    operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      operand = operand | (req_data[i*DATAWIDTH +: DATAWIDTH] & {DATAWIDTH{grant[i]}});
    end
  end

  clz #(
    .DATAWIDTH (DATAWIDTH),
    .CW        (CW)
  ) u_clz (
    .data  (operand),
    .count (clz_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_cnt   <= '0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (handshake) begin
      resp_valid <= 1'b1;
      resp_cnt   <= DATAWIDTH'(clz_count);
      resp_id    <= grant_idx;
      ptr        <= ptr_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clz_arbiter.sv
// Scoreboard bench for clz_arbiter: directed operands with hand-computed counts,
// requester models that hold their operand until accepted, and a negedge monitor.
module tb_clz_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [DW-1:0]      resp_cnt;
  clz_id_t            resp_id;

  clz_arbiter #(
    .NREQ      (NREQ),
    .DATAWIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cnt   (resp_cnt),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int exp_id_q[$];
  int exp_cnt_q[$];
  int eid;
  int ecnt;

  logic [DW-1:0]   ops[NREQ][16];
  int              n_ops[NREQ];
  int              head[NREQ];
  logic [NREQ-1:0] taken;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_op(input int r, input logic [DW-1:0] d);
    ops[r][n_ops[r]] = d;
    n_ops[r]++;
  endtask

  task automatic expect_resp(input int id, input int cnt);
    exp_id_q.push_back(id);
    exp_cnt_q.push_back(cnt);
  endtask

  // Each requester presents its next operand until the cycle it is taken
  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < n_ops[i]) begin
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = ops[i][head[i]];
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DW +: DW]    = '0;
      end
    end
  endtask

  task automatic half_neg();
    @(negedge clk);
    taken = req_ready;
  endtask

  task automatic half_pos();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (taken[i]) head[i]++;
    end
    taken = '0;
    refresh();
  endtask

  task automatic step();
    half_neg();
    half_pos();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_id_q.size() > 0; c++) step();
    check_output("drain_pending", exp_id_q.size(), 0);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    taken      = '0;
    for (int i = 0; i < NREQ; i++) begin
      n_ops[i] = 0;
      head[i]  = 0;
    end

    fork
      forever begin
        @(negedge clk);
        if (rst_n && resp_valid && resp_ready) begin
          if (exp_id_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_resp: got id %0d cnt %0d, want no response",
                     resp_id, resp_cnt);
          end else begin
            eid  = exp_id_q.pop_front();
            ecnt = exp_cnt_q.pop_front();
            check_output("resp_id", int'(resp_id), eid);
            check_output("resp_cnt", int'(resp_cnt), ecnt);
          end
        end
      end
    join_none

    // Reset with every requester valid, then four-way round-robin without stalls
    add_op(0, 32'h0000_0001); add_op(0, 32'h4000_0000);
    add_op(1, 32'h00F0_0000); add_op(1, 32'h0000_0000);
    add_op(2, 32'h0000_8000); add_op(2, 32'h0000_0003);
    add_op(3, 32'hFFFF_FFFF); add_op(3, 32'h0001_0000);
    refresh();
    expect_resp(0, 31); expect_resp(1, 8);  expect_resp(2, 16); expect_resp(3, 0);
    expect_resp(0, 1);  expect_resp(1, 32); expect_resp(2, 30); expect_resp(3, 15);
    repeat (2) begin
      half_neg();
      check_output("reset_req_ready", int'(req_ready), 0);
      check_output("reset_resp_valid", int'(resp_valid), 0);
      half_pos();
    end
    rst_n = 1'b1;
    half_neg();
    check_output("first_grant", int'(req_ready), 1);
    half_pos();
    repeat (8) begin
      half_neg();
      check_output("no_bubble_rr", int'(resp_valid), 1);
      half_pos();
    end
    idle(2);

    // Single requester 2, back to back
    add_op(2, 32'h0000_FFFF); add_op(2, 32'h0000_0000); add_op(2, 32'h8000_0000);
    refresh();
    expect_resp(2, 16); expect_resp(2, 32); expect_resp(2, 0);
    half_neg();
    check_output("single_grant", int'(req_ready), 4);
    half_pos();
    repeat (3) begin
      half_neg();
      check_output("no_bubble_single", int'(resp_valid), 1);
      half_pos();
    end
    idle(2);

    // Backpressure: ptr is 3, so requester 0 goes first and 1 waits behind a stall
    add_op(0, 32'h0000_00FF); add_op(1, 32'h0000_0F00);
    refresh();
    expect_resp(0, 24); expect_resp(1, 20);
    step();
    resp_ready = 1'b0;
    repeat (3) begin
      half_neg();
      check_output("stall_req_ready", int'(req_ready), 0);
      check_output("stall_resp_valid", int'(resp_valid), 1);
      check_output("stall_resp_cnt", int'(resp_cnt), 24);
      check_output("stall_resp_id", int'(resp_id), 0);
      half_pos();
    end
    resp_ready = 1'b1;
    half_neg();
    check_output("drain_accept_grant", int'(req_ready), 2);
    half_pos();
    half_neg();
    check_output("drain_accept_valid", int'(resp_valid), 1);
    half_pos();
    idle(2);

    // Rotation with ptr at 2: requesters 1 and 3 valid
    add_op(1, 32'h0000_0100); add_op(3, 32'h0040_0000);
    refresh();
    expect_resp(3, 9); expect_resp(1, 23);
    half_neg();
    check_output("rotate_first", int'(req_ready), 8);
    half_pos();
    drain();
    idle(3);
    add_op(1, 32'h2000_0000); add_op(3, 32'h0000_0004); add_op(3, 32'h0200_0000);
    refresh();
    expect_resp(3, 29); expect_resp(1, 2); expect_resp(3, 6);
    drain();
    idle(2);

    // Asynchronous reset while a result is held by a stalled consumer
    resp_ready = 1'b0;
    add_op(0, 32'h0000_0001);
    refresh();
    half_neg();
    check_output("held_grant", int'(req_ready), 1);
    half_pos();
    half_neg();
    check_output("held_valid", int'(resp_valid), 1);
    check_output("held_cnt", int'(resp_cnt), 31);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_resp_valid", int'(resp_valid), 0);
    check_output("async_resp_cnt", int'(resp_cnt), 0);
    check_output("async_resp_id", int'(resp_id), 0);
    check_output("async_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    idle(3);
    check_output("final_queue_empty", exp_id_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
